// File: rtl/vector_line_gen.sv
// Vector stroke generator for an 8-bit X/Y DAC display.
// It accepts MOVE/DRAW/END/NOP words through a valid/ready handshake. MOVE is a
// blanked jump followed by a settle dwell. DRAW traces a Bresenham line with the
// beam on, holding each pixel for STEP_DIV clocks.
module vector_line_gen #(
   parameter int DAC_WIDTH  = 8,
   parameter int DATAWIDTH  = 18,
   parameter int STEP_DIV   = 2,
   parameter int MOVE_DWELL = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DAC_WIDTH-1:0] x_dac,
   output logic [DAC_WIDTH-1:0] y_dac,
   output logic                 beam_on,
   output logic                 busy,
   output logic                 frame_done
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DRAW   = 2'd2;

   localparam logic [1:0] CMD_MOVE = 2'b00;
   localparam logic [1:0] CMD_DRAW = 2'b01;
   localparam logic [1:0] CMD_END  = 2'b10;

   // err needs two extra bits over the coordinate width; 2*err needs three.
   localparam int EW    = DAC_WIDTH + 2;
   localparam int E2W   = DAC_WIDTH + 3;
   localparam int CNT_W = $clog2(MOVE_DWELL + STEP_DIV + 1);

   localparam logic [CNT_W-1:0]     DWELL_LOAD = CNT_W'(MOVE_DWELL - 1);
   localparam logic [CNT_W-1:0]     STEP_LOAD  = CNT_W'(STEP_DIV - 1);
   localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DAC_WIDTH-1:0] POS_ZERO   = {DAC_WIDTH{1'b0}};
   localparam logic [DAC_WIDTH-1:0] POS_ONE    = {{(DAC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DAC_WIDTH-1:0] POS_MAX    = {DAC_WIDTH{1'b1}};

   // Absolute coordinate distance, never negative and never wrapping.
   function automatic logic [DAC_WIDTH-1:0] abs_diff(input logic [DAC_WIDTH-1:0] a,
                                                     input logic [DAC_WIDTH-1:0] b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

   logic [1:0]            state_r;
   logic [DAC_WIDTH-1:0]  x_r, y_r, tx_r, ty_r, dx_r, dy_r;
   logic                  sx_r, sy_r;
   logic signed [EW-1:0]  err_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  beam_r, busy_r, ready_r, frame_r;

   logic [1:0]            cmd_s;
   logic [DAC_WIDTH-1:0]  ix_s, iy_s, dx_new_s, dy_new_s;
   logic                  accept_s, step_x_s, step_y_s, at_target_s;
   logic signed [E2W-1:0] e2_s, dx_ext_s, dy_ext_s, err_acc_s;
   logic signed [EW-1:0]  err_init_s, err_nxt_s;
   logic [DAC_WIDTH-1:0]  x_nxt_s, y_nxt_s;

   assign cmd_s    = in_data[DATAWIDTH-1 -: 2];
   assign ix_s     = in_data[2*DAC_WIDTH-1 -: DAC_WIDTH];
   assign iy_s     = in_data[DAC_WIDTH-1:0];
   assign accept_s = in_valid & ready_r;

   assign in_ready   = ready_r;
   assign x_dac      = x_r;
   assign y_dac      = y_r;
   assign beam_on    = beam_r;
   assign busy       = busy_r;
   assign frame_done = frame_r;

   // Bresenham step decision and saturating next-position computation.
   always_comb begin
      dx_new_s    = abs_diff(ix_s, x_r);
      dy_new_s    = abs_diff(iy_s, y_r);
      err_init_s  = $signed({2'b00, dx_new_s}) - $signed({2'b00, dy_new_s});
      e2_s        = $signed({err_r, 1'b0});
      dx_ext_s    = $signed({3'b000, dx_r});
      dy_ext_s    = $signed({3'b000, dy_r});
      step_x_s    = (e2_s > -dy_ext_s);
      step_y_s    = (e2_s < dx_ext_s);
      at_target_s = (x_r == tx_r) && (y_r == ty_r);
      err_acc_s   = $signed({err_r[EW-1], err_r});
      if (step_x_s) begin
         err_acc_s = err_acc_s - dy_ext_s;
      end else begin
         err_acc_s = err_acc_s;
      end
      if (step_y_s) begin
         err_acc_s = err_acc_s + dx_ext_s;
      end else begin
         err_acc_s = err_acc_s;
      end
      err_nxt_s = err_acc_s[EW-1:0];
      x_nxt_s   = x_r;
      y_nxt_s   = y_r;
      if (step_x_s && sx_r && (x_r != POS_MAX)) begin
         x_nxt_s = x_r + POS_ONE;
      end else if (step_x_s && !sx_r && (x_r != POS_ZERO)) begin
         x_nxt_s = x_r - POS_ONE;
      end else begin
         x_nxt_s = x_r;
      end
      if (step_y_s && sy_r && (y_r != POS_MAX)) begin
         y_nxt_s = y_r + POS_ONE;
      end else if (step_y_s && !sy_r && (y_r != POS_ZERO)) begin
         y_nxt_s = y_r - POS_ONE;
      end else begin
         y_nxt_s = y_r;
      end
   end

   // Command FSM: word acceptance, settle dwell, per-pixel stepping and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         x_r     <= POS_ZERO;
         y_r     <= POS_ZERO;
         tx_r    <= POS_ZERO;
         ty_r    <= POS_ZERO;
         dx_r    <= POS_ZERO;
         dy_r    <= POS_ZERO;
         sx_r    <= 1'b0;
         sy_r    <= 1'b0;
         err_r   <= {EW{1'b0}};
         cnt_r   <= CNT_ZERO;
         beam_r  <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b0;
         frame_r <= 1'b0;
      end else begin
         frame_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               ready_r <= 1'b1;
               beam_r  <= 1'b0;
               busy_r  <= 1'b0;
               if (accept_s) begin
                  case (cmd_s)
                     CMD_MOVE: begin
                        x_r     <= ix_s;
                        y_r     <= iy_s;
                        cnt_r   <= DWELL_LOAD;
                        state_r <= ST_SETTLE;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                     end
                     CMD_DRAW: begin
                        tx_r    <= ix_s;
                        ty_r    <= iy_s;
                        dx_r    <= dx_new_s;
                        dy_r    <= dy_new_s;
                        sx_r    <= (ix_s >= x_r);
                        sy_r    <= (iy_s >= y_r);
                        err_r   <= err_init_s;
                        cnt_r   <= STEP_LOAD;
                        state_r <= ST_DRAW;
                        beam_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                     end
                     CMD_END: begin
                        frame_r <= 1'b1;
                     end
                     default: begin
                        frame_r <= 1'b0;
                     end
                  endcase
               end
            end
            ST_SETTLE: begin
               if (cnt_r == CNT_ZERO) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_DRAW: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end else if (at_target_s) begin
                  state_r <= ST_IDLE;
                  beam_r  <= 1'b0;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else begin
                  x_r   <= x_nxt_s;
                  y_r   <= y_nxt_s;
                  err_r <= err_nxt_s;
                  cnt_r <= STEP_LOAD;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               beam_r  <= 1'b0;
               busy_r  <= 1'b0;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
